// File: rtl/gray_step_decoder.sv
// Purpose: tracks a sampled Gray-coded position in binary, reporting legal single steps and flagging jumps.
// Latency: one cycle from a valid_in sample to the registered bin_out/dir/step/err/err_cnt/locked response.
// Backpressure: none; gray_in is consumed on every cycle with valid_in=1 and ignored otherwise.
module gray_step_decoder #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;   // last accepted Gray word; always the Gray image of bin_out while tracking
  logic [WIDTH-1:0] cand;   // most recent Gray word seen while faulted
  logic [WIDTH-1:0] n_bin;
  logic [WIDTH-1:0] bin_up;
  logic [WIDTH-1:0] bin_dn;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Decode the incoming word and form the two legal neighbours (wrapping) of the tracked position.
  always_comb begin
    n_bin  = g2b(gray_in);
    bin_up = bin_out + ONE;
    bin_dn = bin_out - ONE;
  end

  // Sync/track/fault sequencing; pulses default low and only fire on a valid sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SYNC;
      prev    <= '0;
      cand    <= '0;
      bin_out <= '0;
      dir     <= 1'b1;
      step    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      locked  <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      if (valid_in) begin
        case (state)
          SYNC: begin
            prev    <= gray_in;
            bin_out <= n_bin;
            locked  <= 1'b1;
            state   <= TRACK;
          end
          TRACK: begin
            if (gray_in == prev) begin
              // same position: nothing to report
            end else if (n_bin == bin_up) begin
              prev    <= gray_in;
              bin_out <= n_bin;
              dir     <= 1'b1;
              step    <= 1'b1;
            end else if (n_bin == bin_dn) begin
              prev    <= gray_in;
              bin_out <= n_bin;
              dir     <= 1'b0;
              step    <= 1'b1;
            end else begin
              // Jump of more than one code: keep the last good position and wait for a stable word.
              err    <= 1'b1;
              cand   <= gray_in;
              locked <= 1'b0;
              state  <= FAULT;
              if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_ONE;
              end
            end
          end
          FAULT: begin
            // Two consecutive identical samples mean the source has settled; adopt it silently.
            if (gray_in == cand) begin
              prev    <= gray_in;
              bin_out <= n_bin;
              locked  <= 1'b1;
              state   <= TRACK;
            end else begin
              cand <= gray_in;
            end
          end
          default: begin
            state  <= SYNC;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_step_decoder.sv
module tb_gray_step_decoder;

  localparam int W    = 3;
  localparam int MASK = (1 << W) - 1;
  localparam int CMAX = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic         valid_in = 1'b0;
  logic [W-1:0] bin_out;
  logic         dir;
  logic         step;
  logic         err;
  logic [7:0]   err_cnt;
  logic         locked;

  gray_step_decoder #(.WIDTH(W), .ERR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .gray_in  (gray_in),
    .valid_in (valid_in),
    .bin_out  (bin_out),
    .dir      (dir),
    .step     (step),
    .err      (err),
    .err_cnt  (err_cnt),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: position as an integer, "have a position yet" and "faulted" flags.
  int m_bin, m_dir, m_step, m_err, m_cnt, m_locked, m_cand;
  bit m_have, m_faulted;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  function automatic int from_gray(input int g);
    int b = 0;
    for (int x = g; x != 0; x = x >> 1) b = b ^ x;
    return b & MASK;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_update(input bit r, input bit v, input int g);
    int n, d;
    if (r) begin
      m_bin = 0; m_dir = 1; m_step = 0; m_err = 0; m_cnt = 0; m_locked = 0;
      m_cand = 0; m_have = 0; m_faulted = 0;
      return;
    end
    m_step = 0;
    m_err  = 0;
    if (!v) return;
    n = from_gray(g);
    if (!m_have) begin
      m_have = 1; m_bin = n; m_locked = 1;
    end else if (m_faulted) begin
      if (g == m_cand) begin
        m_faulted = 0; m_bin = n; m_locked = 1;
      end else m_cand = g;
    end else begin
      d = (n - m_bin) & MASK;
      if (d == 1) begin
        m_bin = n; m_dir = 1; m_step = 1;
      end else if (d == MASK) begin
        m_bin = n; m_dir = 0; m_step = 1;
      end else if (d != 0) begin
        m_err = 1; m_cand = g; m_locked = 0; m_faulted = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
  endtask

  // Drive one cycle on the falling edge, advance the model on the rising edge.
  task automatic apply(input bit r, input bit v, input int g);
    @(negedge clk);
    reset    = r;
    valid_in = v;
    gray_in  = g[W-1:0];
    @(posedge clk);
    model_update(r, v, g);
    #1;
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bin_out", int'(bin_out), m_bin);
      check("dir",     int'(dir),     m_dir);
      check("step",    int'(step),    m_step);
      check("err",     int'(err),     m_err);
      check("err_cnt", int'(err_cnt), m_cnt);
      check("locked",  int'(locked),  m_locked);
      if (step && err) check("step_err_excl", 1, 0);
    end
  end

  initial begin
    int g, sel;
    bit r, v;

    // 1. reset, first sample, first step
    apply(1, 0, 0);
    apply(1, 0, 0);
    chk_en = 1'b1;
    check("rst_bin", int'(bin_out), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_locked", int'(locked), 0);
    check("rst_cnt", int'(err_cnt), 0);
    apply(0, 1, 3'b000);
    check("sync_locked", int'(locked), 1);
    check("sync_step", int'(step), 0);
    apply(0, 1, 3'b001);
    check("up_step", int'(step), 1);
    check("up_bin", int'(bin_out), 1);

    // 2. walk up to bin 7, wrap up, wrap down
    for (int b = 2; b <= 7; b++) apply(0, 1, to_gray(b));
    check("walk_bin7", int'(bin_out), 7);
    apply(0, 1, 3'b000);
    check("wrap_up_step", int'(step), 1);
    check("wrap_up_dir", int'(dir), 1);
    check("wrap_up_bin", int'(bin_out), 0);
    apply(0, 1, 3'b100);
    check("wrap_dn_dir", int'(dir), 0);
    check("wrap_dn_bin", int'(bin_out), 7);

    // 3. back to 0, then illegal jump and resync
    apply(0, 1, 3'b000);
    apply(0, 1, 3'b011);
    check("jump_err", int'(err), 1);
    check("jump_cnt", int'(err_cnt), 1);
    check("jump_locked", int'(locked), 0);
    check("jump_bin", int'(bin_out), 0);
    apply(0, 1, 3'b010);
    check("fault_err", int'(err), 0);
    check("fault_locked", int'(locked), 0);
    apply(0, 1, 3'b010);
    check("resync_locked", int'(locked), 1);
    check("resync_bin", int'(bin_out), 3);

    // 4. repeated code and invalid toggling
    for (int i = 0; i < 5; i++) apply(0, 1, 3'b010);
    for (int i = 0; i < 5; i++) apply(0, 0, $urandom_range(0, MASK));
    check("idle_bin", int'(bin_out), 3);

    // 5. saturate the error counter
    for (int i = 0; i < 300; i++) begin
      g = to_gray((m_bin + 4) & MASK);
      apply(0, 1, g);
      if (i == 299) check("sat_err_pulse", int'(err), 1);
      apply(0, 1, g);
    end
    check("sat_cnt", int'(err_cnt), 255);

    // 6. reset wins over a valid sample in TRACK
    apply(1, 1, 3'b001);
    check("rst2_bin", int'(bin_out), 0);
    check("rst2_cnt", int'(err_cnt), 0);
    check("rst2_locked", int'(locked), 0);
    apply(0, 1, 3'b110);
    check("rst2_sync_bin", int'(bin_out), 4);
    check("rst2_sync_step", int'(step), 0);

    // Random phase: mostly near-neighbour moves, some jumps, repeats, idles and resets.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (m_faulted && sel < 4) g = m_cand;
      else if (sel < 3) g = to_gray((m_bin + 1) & MASK);
      else if (sel < 6) g = to_gray((m_bin - 1) & MASK);
      else if (sel < 7) g = to_gray(m_bin);
      else g = $urandom_range(0, MASK);
      apply(r, v, g);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
